// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the N-channel SDRAM read/write arbiter:
// request encodings, FSM state encoding and a constant-width helper.
package sdram_arb_pkg;

  localparam logic [1:0] RW_IDLE = 2'b00;
  localparam logic [1:0] RW_RD   = 2'b01;
  localparam logic [1:0] RW_WR   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational priority picker: first requesting channel at or after the
// start pointer (round-robin) or lowest-index requester (fixed priority).
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned PTR_W = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  input  logic              mode,
  output logic [PTR_W-1:0]  winner,
  output logic              valid
);

  int unsigned      start;
  int unsigned      pos;
  logic [PTR_W-1:0] sel;

  // Upward search with wrap; the first hit freezes the winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    start  = mode ? 32'(rr_ptr) : 32'd0;
    pos    = 0;
    sel    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos = start + i;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      sel = PTR_W'(pos);
      if (!valid && req[sel]) begin
        winner = sel;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_rw_arbiter_nch.sv
// N-channel SDRAM access arbiter: grants one client at a time, forwards its
// direction and address, and holds the grant until done or timeout.
module sdram_rw_arbiter_nch
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned RR_MODE   = 1,
  parameter int unsigned MAX_GRANT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        is_wr,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        grant,
  output logic [1:0]               rw_req,
  output logic [ADDR_W-1:0]        rw_addr,
  output logic                     busy,
  output logic                     timeout
);

  localparam int unsigned PTR_W    = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
  localparam int unsigned TMR_W    = (clog2(MAX_GRANT + 1) > 0) ? clog2(MAX_GRANT + 1) : 1;
  localparam int unsigned TMR_LAST = (MAX_GRANT > 0) ? MAX_GRANT - 1 : 0;
  localparam bit          TMO_EN   = (MAX_GRANT > 0);
  localparam bit          RR_EN    = (RR_MODE != 0);

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [1:0]          rw_req_q, rw_req_d;
  logic [ADDR_W-1:0]   rw_addr_q, rw_addr_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [PTR_W-1:0]    gnt_idx_q, gnt_idx_d;

  logic [PTR_W-1:0]    pick_win;
  logic                pick_valid;
  logic [PTR_W-1:0]    ptr_next;
  logic [ADDR_W-1:0]   addr_a [NUM_CH];

  // Unpack the flat per-channel address bus for index-based muxing.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_addr
    assign addr_a[k] = addr[k*ADDR_W +: ADDR_W];
  end

  sdram_arb_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .mode   (RR_EN),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  assign ptr_next = (pick_win == PTR_W'(NUM_CH - 1)) ? '0 : pick_win + PTR_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rw_req_d  = rw_req_q;
    rw_addr_d = rw_addr_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    tmr_d     = tmr_q;
    gnt_idx_d = gnt_idx_q;

    if (!en) begin
      state_d   = ST_IDLE;
      grant_d   = '0;
      rw_req_d  = RW_IDLE;
      rw_addr_d = '0;
      busy_d    = 1'b0;
      tmr_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_d   = ST_GRANT;
            gnt_idx_d = pick_win;
            grant_d   = NUM_CH'(1) << pick_win;
            rw_req_d  = is_wr[pick_win] ? RW_WR : RW_RD;
            rw_addr_d = addr_a[pick_win];
            busy_d    = 1'b1;
            tmr_d     = '0;
            if (RR_EN) rr_ptr_d = ptr_next;
          end
        end
        ST_GRANT: begin
          // Address tracks the owner live; direction stays frozen.
          rw_addr_d = addr_a[gnt_idx_q];
          if (done[gnt_idx_q] || (TMO_EN && tmr_q == TMR_W'(TMR_LAST))) begin
            state_d   = ST_GAP;
            grant_d   = '0;
            rw_req_d  = RW_IDLE;
            busy_d    = 1'b0;
            tmr_d     = '0;
            timeout_d = !done[gnt_idx_q];
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_GAP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rw_req_q  <= RW_IDLE;
      rw_addr_q <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      rr_ptr_q  <= '0;
      tmr_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rw_req_q  <= rw_req_d;
      rw_addr_q <= rw_addr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      rr_ptr_q  <= rr_ptr_d;
      tmr_q     <= tmr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign grant   = grant_q;
  assign rw_req  = rw_req_q;
  assign rw_addr = rw_addr_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sdram_rw_arbiter_nch.sv
// Bench for sdram_rw_arbiter_nch: picker vector table, directed corner-case
// sequences, and randomized traffic against a transaction-level model.
module tb_sdram_rw_arbiter_nch;

  localparam int unsigned N    = 4;
  localparam int unsigned AW   = 24;
  localparam int          MAXG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            en;
  logic [N-1:0]    req, is_wr, done;
  logic [N*AW-1:0] addr;

  logic [N-1:0]  g_rr, g_fx;
  logic [1:0]    rq_rr, rq_fx;
  logic [AW-1:0] a_rr, a_fx;
  logic          b_rr, b_fx, t_rr, t_fx;

  logic [N-1:0] p_req;
  logic [1:0]   p_ptr, p_win;
  logic         p_mode, p_valid;

  int checks = 0;
  int errors = 0;

  sdram_rw_arbiter_nch #(.NUM_CH(N), .ADDR_W(AW), .RR_MODE(1), .MAX_GRANT(MAXG)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .is_wr(is_wr), .addr(addr), .done(done),
    .grant(g_rr), .rw_req(rq_rr), .rw_addr(a_rr), .busy(b_rr), .timeout(t_rr));

  sdram_rw_arbiter_nch #(.NUM_CH(N), .ADDR_W(AW), .RR_MODE(0), .MAX_GRANT(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .is_wr(is_wr), .addr(addr), .done(done),
    .grant(g_fx), .rw_req(rq_fx), .rw_addr(a_fx), .busy(b_fx), .timeout(t_fx));

  sdram_arb_pick #(.NUM_CH(N)) u_pick (
    .req(p_req), .rr_ptr(p_ptr), .mode(p_mode), .winner(p_win), .valid(p_valid));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: owner channel (-1 = none), post-release turnaround, cycles held.
  int          m_owner [2];
  int          m_age   [2];
  int          m_ptr   [2];
  bit          m_gap   [2];
  bit          m_to    [2];
  bit          m_wr    [2];
  bit          m_zaddr [2];
  logic [AW-1:0] m_addr [2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1; m_age[u] = 0; m_ptr[u] = 0; m_gap[u] = 0;
      m_to[u] = 0; m_wr[u] = 0; m_zaddr[u] = 1; m_addr[u] = '0;
    end
  endtask

  task automatic model_step(input int u);
    bit rr;
    int maxg;
    int start;
    int ch;
    rr    = (u == 0);
    maxg  = (u == 0) ? MAXG : 0;
    m_to[u]    = 0;
    m_zaddr[u] = 0;
    if (!en) begin
      m_owner[u] = -1; m_gap[u] = 0; m_age[u] = 0;
      m_zaddr[u] = 1; m_addr[u] = '0;
    end else if (m_owner[u] >= 0) begin
      if (done[m_owner[u]]) begin
        m_owner[u] = -1; m_gap[u] = 1;
      end else if (maxg > 0 && m_age[u] == maxg - 1) begin
        m_owner[u] = -1; m_gap[u] = 1; m_to[u] = 1;
      end else begin
        m_age[u]++;
        m_addr[u] = addr[m_owner[u]*AW +: AW];
      end
    end else if (m_gap[u]) begin
      m_gap[u] = 0;
    end else if (req != '0) begin
      start = rr ? m_ptr[u] : 0;
      ch = -1;
      for (int k = 0; k < N; k++) begin
        if (ch < 0 && req[(start + k) % N]) ch = (start + k) % N;
      end
      m_owner[u] = ch; m_age[u] = 0; m_wr[u] = is_wr[ch];
      m_addr[u] = addr[ch*AW +: AW];
      if (rr) m_ptr[u] = (ch + 1) % N;
    end
  endtask

  task automatic check_u(input int u);
    logic [N-1:0]  g, eg;
    logic [1:0]    rq, erq;
    logic [AW-1:0] a;
    logic          b, t;
    if (u == 0) begin g = g_rr; rq = rq_rr; a = a_rr; b = b_rr; t = t_rr; end
    else        begin g = g_fx; rq = rq_fx; a = a_fx; b = b_fx; t = t_fx; end
    eg  = (m_owner[u] >= 0) ? (N'(1) << m_owner[u]) : '0;
    erq = (m_owner[u] < 0) ? 2'b00 : (m_wr[u] ? 2'b10 : 2'b01);
    chk(u == 0 ? "rr_grant"   : "fx_grant",   64'(g),  64'(eg));
    chk(u == 0 ? "rr_rw_req"  : "fx_rw_req",  64'(rq), 64'(erq));
    chk(u == 0 ? "rr_busy"    : "fx_busy",    64'(b),  64'(m_owner[u] >= 0));
    chk(u == 0 ? "rr_timeout" : "fx_timeout", 64'(t),  64'(m_to[u]));
    if (m_owner[u] >= 0 || m_zaddr[u])
      chk(u == 0 ? "rr_rw_addr" : "fx_rw_addr", 64'(a), 64'(m_addr[u]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_u(0);
    check_u(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; req = '0; is_wr = '0; done = '0; addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant",   64'(g_rr | g_fx), 64'(0));
    chk("rst_rw_req",  64'(rq_rr | rq_fx), 64'(0));
    chk("rst_rw_addr", 64'(a_rr | a_fx), 64'(0));
    chk("rst_busy_to", 64'({b_rr, b_fx, t_rr, t_fx}), 64'(0));
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic wait_busy(input int u, input string name);
    int n;
    n = 0;
    while (((u == 0) ? b_rr : b_fx) !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    if (((u == 0) ? b_rr : b_fx) !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: busy=0 after 16 cycles, expected a grant", name);
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic       mode;
    logic [1:0] win;
    logic       valid;
  } pick_vec_t;

  initial begin
    pick_vec_t pv [10];
    logic [3:0] t1_g  [5];
    logic [1:0] t1_rq [5];
    int idle, busy_n, to_n;

    // Picker vectors: {req, rr_ptr, mode, expected winner, expected valid}.
    pv[0] = '{4'b0000, 2'd0, 1'b1, 2'd0, 1'b0};
    pv[1] = '{4'b1111, 2'd0, 1'b1, 2'd0, 1'b1};
    pv[2] = '{4'b1111, 2'd2, 1'b1, 2'd2, 1'b1};
    pv[3] = '{4'b0011, 2'd2, 1'b1, 2'd0, 1'b1};
    pv[4] = '{4'b1001, 2'd1, 1'b1, 2'd3, 1'b1};
    pv[5] = '{4'b1010, 2'd3, 1'b1, 2'd3, 1'b1};
    pv[6] = '{4'b0100, 2'd3, 1'b1, 2'd2, 1'b1};
    pv[7] = '{4'b1010, 2'd2, 1'b0, 2'd1, 1'b1};
    pv[8] = '{4'b1000, 2'd1, 1'b0, 2'd3, 1'b1};
    pv[9] = '{4'b0110, 2'd3, 1'b0, 2'd1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      p_req = pv[i].req; p_ptr = pv[i].ptr; p_mode = pv[i].mode;
      #1;
      chk($sformatf("pick_valid[%0d]", i), 64'(p_valid), 64'(pv[i].valid));
      if (pv[i].valid) chk($sformatf("pick_win[%0d]", i), 64'(p_win), 64'(pv[i].win));
    end

    // Round-robin order with all channels requesting.
    t1_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t1_rq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req = 4'hF; is_wr = 4'b0101;
    for (int n = 0; n < 5; n++) begin
      idle = 0;
      while (b_rr !== 1'b1 && idle < 16) begin
        idle++;
        tick();
      end
      chk($sformatf("t1_order[%0d]", n), 64'(g_rr), 64'(t1_g[n]));
      chk($sformatf("t1_rw_req[%0d]", n), 64'(rq_rr), 64'(t1_rq[n]));
      if (n > 0) chk($sformatf("t1_idle_cycles[%0d]", n), 64'(idle), 64'(2));
      tick();
      done = g_rr;
      tick();
      done = '0;
    end

    // Fixed priority: channel 1 always beats channel 3.
    do_reset();
    req = 4'b1010; is_wr = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      wait_busy(1, "t2_wait");
      chk($sformatf("t2_grant[%0d]", n), 64'(g_fx), 64'(4'b0010));
      chk($sformatf("t2_rw_req[%0d]", n), 64'(rq_fx), 64'(2'b10));
      tick();
      done = g_fx;
      tick();
      done = '0;
    end

    // Live address tracking with frozen direction.
    do_reset();
    req = 4'b0100; is_wr = 4'b0100; addr[2*AW +: AW] = 24'h000100;
    wait_busy(0, "t3_wait");
    chk("t3_rw_req", 64'(rq_rr), 64'(2'b10));
    chk("t3_addr0",  64'(a_rr),  64'(24'h000100));
    addr[2*AW +: AW] = 24'h000101;
    is_wr = 4'b0000;
    tick();
    chk("t3_addr1",  64'(a_rr),  64'(24'h000101));
    chk("t3_rw_req_frozen", 64'(rq_rr), 64'(2'b10));
    done = 4'b0100;
    tick();
    done = '0;

    // Timeout after MAXG cycles, then pointer resumes after channel 1.
    do_reset();
    req = 4'b0010;
    wait_busy(0, "t4_wait");
    req = '0;
    busy_n = 0; to_n = 0;
    for (int k = 0; k < 14; k++) begin
      if (b_rr === 1'b1) busy_n++;
      tick();
      if (t_rr === 1'b1) to_n++;
    end
    chk("t4_busy_cycles", 64'(busy_n), 64'(MAXG));
    chk("t4_timeout_pulses", 64'(to_n), 64'(1));
    req = 4'b0101;
    wait_busy(0, "t4_wait2");
    chk("t4_rr_ptr", 64'(g_rr), 64'(4'b0100));

    // Enable drop mid-grant, then re-grant one cycle after re-enable.
    do_reset();
    req = 4'b0001; addr[0 +: AW] = 24'hABCDEF;
    wait_busy(0, "t5_wait");
    en = 1'b0;
    tick();
    chk("t5_grant_off",  64'(g_rr),  64'(0));
    chk("t5_rw_req_off", 64'(rq_rr), 64'(0));
    chk("t5_addr_off",   64'(a_rr),  64'(0));
    en = 1'b1;
    tick();
    chk("t5_regrant", 64'(g_rr), 64'(4'b0001));

    // Foreign done ignored; async reset mid-grant clears outputs at once.
    do_reset();
    req = 4'b0001;
    wait_busy(0, "t6_wait");
    done = 4'b1000;
    tick();
    chk("t6_foreign_done", 64'(g_rr), 64'(4'b0001));
    done = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_grant", 64'(g_rr | g_fx), 64'(0));
    chk("t6_async_misc",  64'({rq_rr, b_rr, t_rr}), 64'(0));
    chk("t6_async_addr",  64'(a_rr), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_after_release", 64'(g_rr), 64'(4'b0001));

    // Randomized traffic on both instances against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      en    = ($urandom_range(0, 19) != 0);
      req   = N'($urandom);
      is_wr = N'($urandom);
      for (int k = 0; k < N; k++) begin
        addr[k*AW +: AW] = AW'($urandom);
        done[k] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
